seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Keeps the 16 base operations and adds three things: multi-bit shifts/rotates by a shift amount, an arithmetic shift right, and an unsigned shift-add multiplier.
- Operands are latched on a start/busy/done handshake, so the control unit can issue multi-cycle operations without holding A/B stable.
- Condition codes are registered and defined correctly for every operation.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- operation  in  5  opcode, latched on accept.
- A  in  WIDTH  operand A, latched on accept.
- B  in  WIDTH  operand B, latched on accept.
- Cin  in  1  carry-in, latched on accept.
- shamt  in  SHW  shift/rotate amount, latched on accept.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  registered result.
- C, N, V, Z  out  1 each  registered condition codes.

Behaviour:
- Reset: result, C, N, V, Z, busy and done all go to 0; FSM goes to IDLE. Reset asserted mid-operation aborts the operation and no done is produced.
- Opcodes 0–8 (single cycle): ADD, ADDC, SUB, AND, NAND, OR, NOR, XOR, XNOR.
- Opcodes 13–15 (single cycle): NOT, TwoC (0−A), PASS (result=A).
- Opcodes 9–12 (multi-cycle): LSL, LSR, RL, RR, each by shamt.
- Opcode 16 ASR: arithmetic shift right by shamt, multi-cycle.
- Opcode 17 MUL: unsigned multiply, low WIDTH bits of A*B.
- Opcodes 18–31: treated as PASS.
- FSM states: IDLE, EXEC, SHIFT, MULT, DONE.
  - IDLE & start: latch inputs, set busy, go to EXEC (single-cycle ops), SHIFT, or MULT.
  - IDLE & !start: stay in IDLE.
  - EXEC: compute; result and flags register at the end of this cycle → DONE.
  - SHIFT: shift one bit per cycle; a down-counter loads shamt on accept. shamt=0 → 1 cycle with result=A. Go to DONE when the count reaches 0.
  - MULT: shift-add, one multiplier bit per cycle, exactly WIDTH cycles → DONE.
  - DONE: done=1 for one cycle, busy drops in the same cycle → IDLE. A new start is accepted in the following cycle (IDLE).
- Latency, accept edge to done cycle:
  - single-cycle ops: 2 cycles;
  - shifts: max(shamt,1)+1 cycles;
  - MUL: WIDTH+1 cycles.
- start while busy=1 is ignored. No queueing. Latched operands are unaffected.
- Flags on every op: Z = (result==0); N = result[WIDTH-1].
- ADD/ADDC: C = carry out of WIDTH+1-bit sum. V = both operands same sign and result sign differs.
- SUB: C = NOT borrow (1 when A ≥ B unsigned). V = operands differ in sign and result sign ≠ A sign.
- TwoC: C = (A==0). V = (A == 1 followed by WIDTH-1 zeros, i.e. the most negative value).
- LSL: C = last bit shifted out (A[WIDTH-shamt]).
- LSR/ASR: C = last bit shifted out (A[shamt-1]).
- Rotates: C = final result LSB (RL) or MSB (RR).
- Any shift/rotate with shamt=0: C=0.
- MUL: C = V = 1 when the high WIDTH bits of the full product are nonzero.
- Logic ops and PASS: C=0, V=0.
- result and flags hold their values between operations; they update only in the cycle done is asserted.

Test Plan:
- Reset: drive rst_n low mid-MUL with WIDTH=32 → busy=0, done never pulses, all outputs 0. Release and run ADD 1+1 → done after 2 cycles, result=2, flags C=N=V=Z=0.
- Arithmetic flags:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, N=1, V=1, C=0.
  - ADD 0xFFFFFFFF+1 → result 0, Z=1, C=1, V=0.
  - SUB 5−7 → result 0xFFFFFFFE, N=1, C=0.
- Shifts:
  - LSL 0x80000001 by 1 → result 2, C=1, done 2 cycles after accept.
  - ASR 0x80000000 by 4 → 0xF8000000, done 5 cycles after accept.
  - RR 0x1 by 0 → result 0x1, C=0, done after 2 cycles.
- Multiply: MUL 0x10000×0x10000 → result 0, C=V=1, Z=1, done exactly 33 cycles after accept. MUL 12×13 → result 156, C=V=0.
- Handshake: pulse start with ADD during a running MUL → ignored; MUL result unchanged. A start issued in the DONE cycle is ignored; the same start held one more cycle is accepted.
- Parametrisation: WIDTH=8, ADD 0x7F+0x01 → result 0x80, V=1, N=1. MUL 16×16 → result 0x00, C=1, done after 9 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake: base ops in one EXEC cycle,
// bit-serial shifts/rotates and a WIDTH-cycle shift-add multiplier.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             C,
    output logic             N,
    output logic             V,
    output logic             Z
);
    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_NAND = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_NOR  = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_XNOR = 5'd8;
    localparam logic [4:0] OP_LSL  = 5'd9;
    localparam logic [4:0] OP_LSR  = 5'd10;
    localparam logic [4:0] OP_RL   = 5'd11;
    localparam logic [4:0] OP_RR   = 5'd12;
    localparam logic [4:0] OP_NOT  = 5'd13;
    localparam logic [4:0] OP_TWOC = 5'd14;
    localparam logic [4:0] OP_ASR  = 5'd16;
    localparam logic [4:0] OP_MUL  = 5'd17;

    typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MULT, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_out;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               fin;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c, fin_v;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_RL) ||
               (op == OP_RR)  || (op == OP_ASR);
    endfunction

    always_comb begin
        sum_w   = {1'b0, acc_q} + {1'b0, b_q} + W1'(cin_q & (op_q == OP_ADDC));
        diff_w  = {1'b0, acc_q} - {1'b0, b_q};
        alu_res = acc_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDC: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (acc_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = ~diff_w[WIDTH];
                alu_v   = (acc_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_AND:  alu_res = acc_q & b_q;
            OP_NAND: alu_res = ~(acc_q & b_q);
            OP_OR:   alu_res = acc_q | b_q;
            OP_NOR:  alu_res = ~(acc_q | b_q);
            OP_XOR:  alu_res = acc_q ^ b_q;
            OP_XNOR: alu_res = ~(acc_q ^ b_q);
            OP_NOT:  alu_res = ~acc_q;
            OP_TWOC: begin
                alu_res = '0 - acc_q;
                alu_c   = (acc_q == '0);
                alu_v   = (acc_q == MOST_NEG);
            end
            default: alu_res = acc_q;
        endcase
    end

    // For rotates the bit leaving one end is the bit entering the other, so
    // sh_out is also the final LSB (RL) / MSB (RR) that C must report.
    always_comb begin
        sh_nxt = acc_q;
        sh_out = 1'b0;
        case (op_q)
            OP_LSL: begin sh_nxt = {acc_q[WIDTH-2:0], 1'b0};           sh_out = acc_q[WIDTH-1]; end
            OP_LSR: begin sh_nxt = {1'b0, acc_q[WIDTH-1:1]};           sh_out = acc_q[0];       end
            OP_ASR: begin sh_nxt = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; sh_out = acc_q[0];       end
            OP_RL:  begin sh_nxt = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]}; sh_out = acc_q[WIDTH-1]; end
            OP_RR:  begin sh_nxt = {acc_q[0], acc_q[WIDTH-1:1]};       sh_out = acc_q[0];       end
            default: ;
        endcase
        prod_nxt = prod_q + (b_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cin_d    = cin_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        c_d      = c_q;
        n_d      = n_q;
        v_d      = v_q;
        z_d      = z_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fin      = 1'b0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = operation;
                    acc_d   = A;
                    b_d     = B;
                    cin_d   = Cin;
                    prod_d  = '0;
                    mcand_d = {{WIDTH{1'b0}}, A};
                    busy_d  = 1'b1;
                    if (is_shift(operation)) begin
                        cnt_d   = CW'(shamt);
                        state_d = SHIFT;
                    end else if (operation == OP_MUL) begin
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = MULT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                fin     = 1'b1;
                fin_res = alu_res;
                fin_c   = alu_c;
                fin_v   = alu_v;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_res = acc_q;
                end else begin
                    acc_d = sh_nxt;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        fin     = 1'b1;
                        fin_res = sh_nxt;
                        fin_c   = sh_out;
                    end
                end
            end
            MULT: begin
                prod_d  = prod_nxt;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_res = prod_nxt[WIDTH-1:0];
                    fin_c   = |prod_nxt[2*WIDTH-1:WIDTH];
                    fin_v   = |prod_nxt[2*WIDTH-1:WIDTH];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fin) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = fin_res;
            c_d      = fin_c;
            v_d      = fin_v;
            n_d      = fin_res[WIDTH-1];
            z_d      = (fin_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            c_q      <= c_d;
            n_q      <= n_d;
            v_q      <= v_d;
            z_q      <= z_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign C      = c_q;
    assign N      = n_q;
    assign V      = v_q;
    assign Z      = z_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu at WIDTH=32 and WIDTH=8: expected results
// are queued at accept and compared (value, flags, latency) when done pulses.
module tb_seq_alu;
    typedef struct {
        logic [31:0] res;
        logic        c, n, v, z;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        start32, cin32, busy32, done32, c32, n32, v32, z32;
    logic [4:0]  op32, sh32;
    logic [31:0] a32, b32, res32;
    logic        start8, cin8, busy8, done8, c8, n8, v8, z8;
    logic [4:0]  op8;
    logic [2:0]  sh8;
    logic [7:0]  a8, b8, res8;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t e32, e8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .operation(op32), .A(a32), .B(b32),
        .Cin(cin32), .shamt(sh32), .busy(busy32), .done(done32), .result(res32),
        .C(c32), .N(n32), .V(v32), .Z(z32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .operation(op8), .A(a8), .B(b8),
        .Cin(cin8), .shamt(sh8), .busy(busy8), .done(done8), .result(res8),
        .C(c8), .N(n8), .V(v8), .Z(z8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic [4:0] sh);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] r;
        logic        c, v;
        int          k;
        k = int'(sh);
        c = 1'b0;
        v = 1'b0;
        e.lat = 2;
        case (op)
            5'd0, 5'd1: begin
                s = {1'b0, a} + {1'b0, b} + ((op == 5'd1 && cin) ? 33'd1 : 33'd0);
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd2: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd3:  r = a & b;
            5'd4:  r = ~(a & b);
            5'd5:  r = a | b;
            5'd6:  r = ~(a | b);
            5'd7:  r = a ^ b;
            5'd8:  r = ~(a ^ b);
            5'd9: begin
                r = a << k;
                c = (k == 0) ? 1'b0 : a[32-k];
            end
            5'd10: begin
                r = a >> k;
                c = (k == 0) ? 1'b0 : a[k-1];
            end
            5'd11: begin
                r = (k == 0) ? a : ((a << k) | (a >> (32 - k)));
                c = (k == 0) ? 1'b0 : r[0];
            end
            5'd12: begin
                r = (k == 0) ? a : ((a >> k) | (a << (32 - k)));
                c = (k == 0) ? 1'b0 : r[31];
            end
            5'd13: r = ~a;
            5'd14: begin
                r = 32'd0 - a;
                c = (a == 32'd0);
                v = (a == 32'h8000_0000);
            end
            5'd16: begin
                r = $signed(a) >>> k;
                c = (k == 0) ? 1'b0 : a[k-1];
            end
            5'd17: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
                c = |p[63:32];
                v = c;
                e.lat = 33;
            end
            default: r = a;
        endcase
        if (op inside {5'd9, 5'd10, 5'd11, 5'd12, 5'd16})
            e.lat = ((k == 0) ? 1 : k) + 1;
        e.res = r;
        e.c   = c;
        e.v   = v;
        e.n   = r[31];
        e.z   = (r == 32'd0);
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n && done32) begin
            if (sb32.size() == 0) begin
                check("w32_unexpected_done", 1, 0);
            end else begin
                e32 = sb32.pop_front();
                check("w32_result", res32, e32.res);
                check("w32_flags_cnvz", {c32, n32, v32, z32}, {e32.c, e32.n, e32.v, e32.z});
                check("w32_latency", cyc - e32.acc + 1, e32.lat);
                check("w32_busy_at_done", busy32, 0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && done8) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_done", 1, 0);
            end else begin
                e8 = sb8.pop_front();
                check("w8_result", {24'd0, res8}, e8.res);
                check("w8_flags_cnvz", {c8, n8, v8, z8}, {e8.c, e8.n, e8.v, e8.z});
                check("w8_latency", cyc - e8.acc + 1, e8.lat);
            end
        end
    end

    task automatic drive32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [4:0] sh);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b; cin32 = cin; sh32 = sh;
    endtask

    task automatic push32(input exp_t e);
        e.acc = cyc;
        sb32.push_back(e);
        check("w32_busy_on_accept", busy32, 1);
    endtask

    task automatic wait_idle32();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb32.size() == 0) return;
        end
        check("w32_done_timeout", 1, 0);
        sb32.delete();
    endtask

    task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [4:0] sh);
        @(negedge clk);
        drive32(op, a, b, cin, sh);
        @(posedge clk);
        #1;
        push32(model32(op, a, b, cin, sh));
        @(negedge clk);
        start32 = 1'b0;
        wait_idle32();
    endtask

    task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh, input logic [7:0] r, input logic [3:0] cnvz, input int lat);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b; cin8 = 1'b0; sh8 = sh;
        @(posedge clk);
        #1;
        e.res = {24'd0, r};
        {e.c, e.n, e.v, e.z} = cnvz;
        e.lat = lat;
        e.acc = cyc;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb8.size() == 0) break;
            @(negedge clk);
        end
        if (sb8.size() != 0) begin
            check("w8_done_timeout", 1, 0);
            sb8.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; cin32 = 1'b0; sh32 = '0;
        start8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;  cin8 = 1'b0;  sh8 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {res32, c32, n32, v32, z32, busy32, done32}, 0);
        check("reset_outputs_w8", {res8, c8, n8, v8, z8, busy8, done8}, 0);
        rst_n = 1'b1;

        // Leave a nonzero result behind, then abort a MUL with reset.
        run32(5'd0, 32'd1, 32'd2, 1'b0, 5'd0);
        @(negedge clk);
        drive32(5'd17, 32'd7, 32'd9, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        push32(model32(5'd17, 32'd7, 32'd9, 1'b0, 5'd0));
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midmul_reset_outputs", {res32, c32, n32, v32, z32, busy32, done32}, 0);
        sb32.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midmul_reset_result_held", res32, 0);

        run32(5'd0, 32'd1, 32'd1, 1'b0, 5'd0);
        run32(5'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 5'd0);
        run32(5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0);
        run32(5'd1, 32'hFFFF_FFFE, 32'd1, 1'b1, 5'd0);
        run32(5'd2, 32'd5, 32'd7, 1'b0, 5'd0);
        run32(5'd14, 32'h8000_0000, 32'd0, 1'b0, 5'd0);
        run32(5'd14, 32'd0, 32'd0, 1'b0, 5'd0);
        run32(5'd9, 32'h8000_0001, 32'd0, 1'b0, 5'd1);
        run32(5'd16, 32'h8000_0000, 32'd0, 1'b0, 5'd4);
        run32(5'd12, 32'd1, 32'd0, 1'b0, 5'd0);
        run32(5'd11, 32'hC000_0001, 32'd0, 1'b0, 5'd3);
        run32(5'd10, 32'hF0F0_0F0F, 32'd0, 1'b0, 5'd31);
        run32(5'd17, 32'h0001_0000, 32'h0001_0000, 1'b0, 5'd0);
        run32(5'd17, 32'd12, 32'd13, 1'b0, 5'd0);
        run32(5'd25, 32'h1234_5678, 32'd0, 1'b0, 5'd0);

        // A start pulse while a MUL is busy must not disturb it.
        @(negedge clk);
        drive32(5'd17, 32'hFFFF_FFFF, 32'd3, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        push32(model32(5'd17, 32'hFFFF_FFFF, 32'd3, 1'b0, 5'd0));
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        drive32(5'd0, 32'd1, 32'd1, 1'b0, 5'd0);
        @(negedge clk);
        start32 = 1'b0;
        wait_idle32();

        // Start raised in the DONE cycle is ignored, then taken a cycle later.
        @(negedge clk);
        drive32(5'd7, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        push32(model32(5'd7, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 5'd0));
        @(negedge clk);
        start32 = 1'b0;
        wait_idle32();
        drive32(5'd2, 32'd9, 32'd4, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        check("start_in_done_ignored", busy32, 0);
        @(posedge clk);
        #1;
        push32(model32(5'd2, 32'd9, 32'd4, 1'b0, 5'd0));
        @(negedge clk);
        start32 = 1'b0;
        wait_idle32();

        for (int i = 0; i < 30; i++)
            run32(5'($urandom_range(0, 31)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)));

        run8(5'd0,  8'h7F, 8'h01, 3'd0, 8'h80, 4'b0110, 2);
        run8(5'd17, 8'd16, 8'd16, 3'd0, 8'h00, 4'b1011, 9);
        run8(5'd2,  8'd3,  8'd5,  3'd0, 8'hFE, 4'b0100, 2);
        run8(5'd9,  8'h81, 8'd0,  3'd1, 8'h02, 4'b1000, 2);
        run8(5'd16, 8'h80, 8'd0,  3'd7, 8'hFF, 4'b0100, 8);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
